// File: rtl/seq_multdiv.sv
// Iterative signed multiply/divide: shift-add multiply and restoring divide, one bit per cycle.
// Define SEQ_MULTDIV_REMAINDER_EN to add the signed data_remainder output.
module seq_multdiv #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
`ifdef SEQ_MULTDIV_REMAINDER_EN
  ,
  output logic [WIDTH-1:0] data_remainder
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  // Handshake: a start is a one-cycle high on ctrl_MULT or ctrl_DIV at any edge;
  // data_resultRDY is a one-cycle strobe qualifying data_result/data_exception.
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    counter;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [2*WIDTH-1:0] acc;  // MUL: {partial sum, multiplier shift reg}; DIV: {R, Q}
  logic             op_div, op_neg, b_zero, div_ovf;

  logic             start;
  logic [WIDTH-1:0] a_abs_in, b_abs_in;
  logic [WIDTH:0]   mul_sum;
  logic [2*WIDTH-1:0] mul_step, div_step;
  logic [WIDTH-1:0] div_r;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] fin_result;
  logic             fin_exception;

  assign start    = ctrl_MULT | ctrl_DIV;
  assign a_abs_in = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign b_abs_in = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = ctrl_MULT ? MUL : DIV;
    end else begin
      case (state)
        MUL, DIV: if (counter == LAST) state_nxt = DONE;
        DONE:     state_nxt = IDLE;
        default:  state_nxt = IDLE;
      endcase
    end
  end

  // Iteration steps and final result formatting
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, abs_a};
    mul_step = acc[0] ? {mul_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
    div_r    = acc[2*WIDTH-2:WIDTH-1];
    div_step = (div_r >= abs_b) ? {div_r - abs_b, acc[WIDTH-2:0], 1'b1}
                                : {div_r, acc[WIDTH-2:0], 1'b0};
    prod     = op_neg ? -acc : acc;
    quot     = op_neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    fin_result    = prod[WIDTH-1:0];
    // Overflow when the upper half is not a pure sign extension of bit WIDTH-1
    fin_exception = ~(&prod[2*WIDTH-1:WIDTH-1]) & (|prod[2*WIDTH-1:WIDTH-1]);
    if (op_div) begin
      if (b_zero) begin
        fin_result    = '0;
        fin_exception = 1'b1;
      end else begin
        fin_result    = quot;
        fin_exception = div_ovf;
      end
    end
  end

`ifdef SEQ_MULTDIV_REMAINDER_EN
  logic             a_neg;
  logic [WIDTH-1:0] fin_rem;

  always_comb begin
    fin_rem = '0;
    if (op_div && !b_zero)
      fin_rem = a_neg ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      a_neg          <= 1'b0;
      data_remainder <= '0;
    end else if (start) begin
      a_neg <= data_operandA[WIDTH-1];
    end else if (state == DONE) begin
      data_remainder <= fin_rem;
    end
  end
`endif

  // Datapath and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      counter        <= '0;
      abs_a          <= '0;
      abs_b          <= '0;
      acc            <= '0;
      op_div         <= 1'b0;
      op_neg         <= 1'b0;
      b_zero         <= 1'b0;
      div_ovf        <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (start) begin
        counter <= '0;
        abs_a   <= a_abs_in;
        abs_b   <= b_abs_in;
        op_div  <= ~ctrl_MULT;
        op_neg  <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        b_zero  <= (data_operandB == '0);
        div_ovf <= (data_operandA == MIN_VAL) && (data_operandB == '1);
        acc     <= ctrl_MULT ? {{WIDTH{1'b0}}, b_abs_in} : {{WIDTH{1'b0}}, a_abs_in};
      end else begin
        case (state)
          MUL: begin
            acc     <= mul_step;
            counter <= counter + CW'(1);
          end
          DIV: begin
            acc     <= div_step;
            counter <= counter + CW'(1);
          end
          DONE: begin
            data_result    <= fin_result;
            data_exception <= fin_exception;
            data_resultRDY <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seq_multdiv.sv
// Scoreboard bench for seq_multdiv: expected results are modelled with native signed
// arithmetic at start time and compared when data_resultRDY strobes.
module tb_seq_multdiv;
  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset;
  logic [W-1:0] data_operandA, data_operandB;
  logic         ctrl_MULT, ctrl_DIV;
  logic [W-1:0] data_result;
  logic         data_exception, data_resultRDY;
`ifdef SEQ_MULTDIV_REMAINDER_EN
  logic [W-1:0] data_remainder;
`endif

  seq_multdiv #(.WIDTH(W)) dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
`ifdef SEQ_MULTDIV_REMAINDER_EN
    ,
    .data_remainder (data_remainder)
`endif
  );

  // clock / reset
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  int cycle = 0;
  int start_cyc = 0;
  int rdy_cnt = 0;
  logic prev_rdy = 1'b0;
  logic [W-1:0] last_result = '0;
  logic [2*W:0] exp_q[$];  // {exception, result, remainder}

  always @(posedge clock) cycle <= cycle + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  function automatic logic [2*W:0] model(input logic m, input logic [W-1:0] a, input logic [W-1:0] b);
    longint p;
    logic [63:0] pv;
    int sa, sb, q, r;
    if (m) begin
      p  = longint'($signed(a)) * longint'($signed(b));
      pv = p;
      return {(p != longint'($signed(pv[31:0]))), pv[31:0], 32'h0};
    end
    sa = a;
    sb = b;
    if (sb == 0) return {1'b1, 32'h0, 32'h0};
    if (sa == 32'sh8000_0000 && sb == -1) return {1'b1, 32'h8000_0000, 32'h0};
    q = sa / sb;
    r = sa % sb;
    return {1'b0, q, r};
  endfunction

  // driver: one-cycle start strobe, then scramble the operand buses
  task automatic start_op(input logic m, input logic d, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clock);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT = m;
    ctrl_DIV = d;
    exp_q.delete();  // any in-flight operation is aborted
    exp_q.push_back(model(m, a, b));
    start_cyc = cycle + 1;
    @(negedge clock);
    ctrl_MULT = 1'b0;
    ctrl_DIV = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clock);
    check("timeout_pending", 64'(exp_q.size()), 64'd0);
    @(negedge clock);
  endtask

  // scoreboard monitor
  always @(negedge clock) begin
    logic [2*W:0] item;
    if (data_resultRDY) begin
      rdy_cnt++;
      check("rdy_width", 64'(prev_rdy), 64'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_rdy", 64'(exp_q.size()), 64'd1);
      end else begin
        item = exp_q.pop_front();
        check("result", 64'(data_result), 64'(item[2*W-1:W]));
        check("exception", 64'(data_exception), 64'(item[2*W]));
`ifdef SEQ_MULTDIV_REMAINDER_EN
        check("remainder", 64'(data_remainder), 64'(item[W-1:0]));
`endif
        check("latency", 64'(cycle - start_cyc), 64'd33);
        last_result = item[2*W-1:W];
      end
    end
    prev_rdy = data_resultRDY;
  end

  initial begin
    int base;
    logic m;
    logic [W-1:0] a, b;
    reset = 1'b1;
    ctrl_MULT = 1'b0;
    ctrl_DIV = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (3) @(negedge clock);
    check("reset_result", 64'(data_result), 64'd0);
    check("reset_exc", 64'(data_exception), 64'd0);
    check("reset_rdy", 64'(data_resultRDY), 64'd0);
    check("reset_state", 64'(dut.state), 64'd0);
    reset = 1'b0;

    // directed cases
    start_op(1, 0, 32'd7, -32'sd3);               wait_done();
    start_op(1, 0, 32'h0001_0000, 32'h0001_0000); wait_done();
    start_op(1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("hold_after_start", 64'(data_result), 64'(32'h0));
    wait_done();
    start_op(0, 1, -32'sd17, 32'd5);              wait_done();
    start_op(0, 1, 32'd100, 32'd0);               wait_done();
    start_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF); wait_done();
    start_op(1, 0, 32'h8000_0000, 32'h8000_0000); wait_done();
    start_op(0, 1, 32'h8000_0000, 32'd1);         wait_done();
    check("hold_idle", 64'(data_result), 64'(last_result));

    // abort: MULT restarted as DIV about ten cycles in
    base = rdy_cnt;
    start_op(1, 0, 32'd3, 32'd4);
    repeat (8) @(negedge clock);
    start_op(0, 1, 32'd20, 32'd6);
    wait_done();
    check("abort_rdy_count", 64'(rdy_cnt - base), 64'd1);

    // both strobes together: multiply wins
    start_op(1, 1, 32'd2, 32'd5);                 wait_done();

    // reset in the middle of a multiply
    start_op(1, 0, 32'd123, 32'd456);
    repeat (13) @(negedge clock);
    reset = 1'b1;
    exp_q.delete();
    @(negedge clock);
    check("midrst_result", 64'(data_result), 64'd0);
    check("midrst_exc", 64'(data_exception), 64'd0);
    check("midrst_rdy", 64'(data_resultRDY), 64'd0);
    reset = 1'b0;
    base = rdy_cnt;
    repeat (40) @(negedge clock);
    check("midrst_no_rdy", 64'(rdy_cnt - base), 64'd0);
    start_op(0, 1, 32'd1000, -32'sd7);            wait_done();

    // random mix
    for (int i = 0; i < 24; i++) begin
      m = 1'($urandom_range(0, 1));
      a = (i % 3 == 0) ? 32'($signed($urandom_range(0, 200)) - 100) : $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'($signed($urandom_range(0, 20)) - 10);
        1:       b = $urandom & 32'h0000_FFFF;
        default: b = $urandom;
      endcase
      start_op(m, ~m, a, b);
      wait_done();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seq_multdiv.md
Name: seq_multdiv

Overview:
- Iterative signed 32-bit multiply/divide unit in the execute stage.
- Sits beside the ALU bitwise/arithmetic datapath and takes the same operand A/B buses from the D/X latch.
- Produces a result, an exception flag and a one-cycle ready strobe. The pipeline stalls on these and forwards the result to the X/M latch.
- Shift-add multiply and restoring divide, one bit per cycle.

Parameters:
- WIDTH, 32, operand and result width; counter width is clog2(WIDTH).

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- data_operandA  input  WIDTH  multiplicand / dividend, two's complement
- data_operandB  input  WIDTH  multiplier / divisor, two's complement
- ctrl_MULT  input  1  start-multiply pulse, sampled every edge
- ctrl_DIV  input  1  start-divide pulse, sampled every edge
- data_result  output  WIDTH  low WIDTH bits of the product, or the quotient
- data_exception  output  1  overflow / divide-by-zero flag, valid with ready
- data_resultRDY  output  1  one-cycle strobe: result and exception valid

Behaviour:
- Reset (synchronous, active-high) clears all state and outputs:
  - state=IDLE, counter=0
  - data_result=0, data_exception=0, data_resultRDY=0
- States: IDLE, MUL, DIV, DONE.
- Start: at any edge where ctrl_MULT or ctrl_DIV is 1, in any state:
  - capture A and B and their signs
  - counter=0
  - next state is MUL, or DIV for a divide
- Start priority:
  - if both strobes are 1 in the same cycle, MULT wins.
  - a start while in MUL, DIV or DONE aborts the current operation and restarts; no ready is issued for the aborted operation.
- MUL, one iteration per edge: if the LSB of |B| shift register is 1, add |A| into the upper half of the 2*WIDTH accumulator; then shift right.
- DIV, one iteration per edge, restoring: shift {R,Q} left; if R >= |B|, then R -= |B| and Q[0]=1.
- When counter==WIDTH-1, the next edge enters DONE:
  - data_result, data_exception and data_resultRDY are registered on that edge.
  - data_resultRDY is high for exactly one cycle, WIDTH+1 edges after the start edge (33 for WIDTH=32).
  - DONE then goes to IDLE; data_resultRDY drops to 0.
- data_result and data_exception hold their values after DONE until the next result is registered. They are not cleared on start.
- Sign fix-up:
  - product is negated if sign(A) differs from sign(B).
  - quotient is negated if sign(A) differs from sign(B), truncating toward zero.
- Exception rules:
  - MUL: exception=1 if the full 2*WIDTH signed product is not the sign-extension of its low WIDTH bits.
  - DIV, B==0: exception=1, result=0. Latency is unchanged.
  - DIV, A=0x80000000 and B=0xFFFFFFFF: exception=1, result=0x80000000.
- Operands captured at start are used throughout; operand buses may change freely after the start edge.
- reset asserted mid-operation returns to IDLE on that edge and suppresses ready.
- Negating |0x80000000| yields 0x80000000 and is handled by two's-complement wrap with no extra logic.

Optional Feature:
- Macro: SEQ_MULTDIV_REMAINDER_EN.
- When defined:
  - adds output port data_remainder, width WIDTH.
  - valid with data_resultRDY; registered like data_result.
  - DIV: signed remainder; its sign follows the dividend, so A == Q*B + rem.
  - MUL or divide-by-zero: 0.
  - reset value is 0.
- When undefined: the port and remainder output register are absent; the restoring-divide datapath and the other outputs are unchanged.

Test Plan:
- MULT pulse, A=7, B=-3 -> ready exactly 33 cycles after the start edge; result=0xFFFFFFEB, exception=0; ready high for 1 cycle only.
- MULT, A=0x00010000, B=0x00010000 -> result=0x00000000, exception=1 (overflow). MULT, A=-1, B=-1 -> result=1, exception=0.
- DIV, A=-17, B=5 -> result=0xFFFFFFFD, exception=0; with SEQ_MULTDIV_REMAINDER_EN, data_remainder=0xFFFFFFFE.
- DIV, A=100, B=0 -> result=0, exception=1 at cycle 33. DIV, A=0x80000000, B=-1 -> result=0x80000000, exception=1.
- MULT A=3, B=4 started, then at cycle 10 DIV A=20, B=6 -> no ready at cycle 33 of the first operation; ready 33 cycles after the DIV start, result=3. Both strobes in one cycle, A=2, B=5 -> result=10, i.e. multiply.
- reset pulsed at cycle 15 of a MULT -> all outputs 0 on the next cycle; ready never asserts; the next start completes normally.
